sync_ack_responder: RTL and testbench
=====================================

// Module: sync_ack_responder
// PURPOSE
//  - Clock-B endpoint of the 4-phase req/ack level handshake that carries transfers from domain A.
//  - Synchronises the incoming req level, captures the A-side data word and presents it as a
//    vld/rdy beat to the local consumer.
//  - Returns the ack level to domain A only after the consumer accepts the beat.
//  - Single clock; sits between the CDC wires and the clk_b consumer logic.
// PARAMETERS
//  - DATA_W       8     width of the transferred word
//  - SYNC_STAGES  2     flops in the req synchroniser chain (legal >= 2)
//  - TIMEOUT_CYC  1024  ack-phase watchdog limit in clk_b cycles (used only with HS_RX_TIMEOUT_EN)
// PORTS
//  clk_b         in   1       clock, domain B
//  b_reset_n_in  in   1       asynchronous reset, active low
//  a_req_in      in   1       req level from domain A (asynchronous to clk_b)
//  a_data_in     in   DATA_W  A-side data; stable while a_req_in is high
//  b_ack_out     out  1       ack level to domain A, registered
//  b_vld_out     out  1       beat valid to consumer
//  b_data_out    out  DATA_W  beat data; held while b_vld_out is high
//  b_rdy_in      in   1       consumer ready
//  b_busy_out    out  1       high in every state except IDLE
//  b_err_out     out  1       sticky ack-phase timeout flag
// BEHAVIOUR
//  - Reset: all outputs 0, b_data_out 0, synchroniser flops 0, state SETTLE.
//  - req_s is the last stage of the SYNC_STAGES chain; the FSM uses only req_s.
//  - SETTLE: discards any transfer left over from reset.
//    - req_s=1 -> ACK (ack rises; no beat delivered; the transfer is dropped so A can complete).
//    - req_s=0 -> IDLE.
//  - IDLE: on req_s=1, register a_data_in into b_data_out, set b_vld_out, go to VALID.
//    - a_data_in is safe to sample because req has been stable for >= SYNC_STAGES edges.
//  - VALID: b_vld_out=1 and b_data_out is held.
//    - On b_vld_out & b_rdy_in: clear b_vld_out, set b_ack_out, go to ACK.
//    - A consumer with rdy already high accepts in the first vld cycle.
//  - ACK: b_ack_out=1. On req_s=0, clear b_ack_out and go to IDLE.
//  - Latency:
//    - a_req_in rise to b_vld_out high: SYNC_STAGES+1 clk_b edges.
//    - Accept to b_ack_out high: 1 edge.
//    - req_s low to b_ack_out low: 1 edge.
//  - Exactly one beat per req rising level; a new beat is impossible until ack has dropped.
//  - A req glitch that never reaches req_s has no effect.
//  - b_rdy_in outside VALID is ignored. a_data_in is sampled only on the IDLE->VALID edge.
//  - Reset mid-operation: an in-flight beat is lost. With A still holding req, the ack is completed via SETTLE.
// CONFIGURATION
//  - Macro: HS_RX_TIMEOUT_EN.
//  - Defined:
//    - A $clog2(TIMEOUT_CYC+1)-bit counter clears on entry to ACK and increments each ACK cycle.
//    - When the count reaches TIMEOUT_CYC with req_s still 1, b_err_out is set.
//    - b_err_out stays 1 until reset. The FSM stays in ACK; the flag does not alter the handshake.
//  - Undefined: no counter; b_err_out is tied 0.
// STRUCTURE
//  - Package hs_cdc_pkg holds:
//    - the state enum: SETTLE, IDLE, VALID, ACK (2 bits);
//    - the default localparams HS_SYNC_STAGES_DEF=2 and HS_TIMEOUT_DEF=1024.
//  - One sub-module, level_synchronizer (WIDTH=1, STAGES): an async-reset-low flop chain.
//    - The domain-A sender reuses it for ack.
//  - All remaining logic (FSM, data register, watchdog) is in this module.
// TESTING
//  - Basic transfer: reset; a_req_in=1, a_data_in=8'hA5, b_rdy_in=1.
//    -> b_vld_out high at edge 3, b_data_out=8'hA5 for 1 cycle, b_ack_out high at edge 4.
//    -> After a_req_in=0, b_ack_out low 3 edges later.
//  - Backpressure: b_rdy_in=0 for 10 cycles after vld.
//    -> b_vld_out and b_data_out held 10 cycles; b_ack_out stays 0 until the accept cycle.
//  - Data mutation: change a_data_in to 8'h3C after the IDLE->VALID edge while req is high.
//    -> b_data_out stays 8'hA5.
//  - Back-to-back: 4 transfers 8'h01..8'h04 with the A-side model obeying 4-phase.
//    -> Exactly 4 beats in order; no duplicate beat while ack is high.
//  - Reset mid-transfer: assert b_reset_n_in=0 in VALID while a_req_in stays 1.
//    -> Outputs 0. After release: no beat; b_ack_out rises within SYNC_STAGES+1 edges.
//    -> After req drops: IDLE.
//  - HS_RX_TIMEOUT_EN, TIMEOUT_CYC=16: hold a_req_in high after ack.
//    -> b_err_out=1 after 16 ACK cycles and stays 1 until reset. Without the macro, b_err_out stays 0.

Source files
------------

// File: rtl/hs_cdc_pkg.sv
// ---------------------------------------------------------------------------
// hs_cdc_pkg
//   Shared definitions for the 4-phase req/ack clock-domain-crossing handshake.
//   Holds the receiver FSM state encoding and the default build parameters
//   used by both ends of the link.
// ---------------------------------------------------------------------------
package hs_cdc_pkg;

  // Receiver FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    IDLE   = 2'd1,
    VALID  = 2'd2,
    ACK    = 2'd3
  } hs_state_e;

  // Default synchroniser depth (legal values are >= 2).
  localparam int HS_SYNC_STAGES_DEF = 2;

  // Default ack-phase watchdog limit in receiver clock cycles.
  localparam int HS_TIMEOUT_DEF = 1024;

endpackage : hs_cdc_pkg

// File: rtl/level_synchronizer.sv
// ---------------------------------------------------------------------------
// level_synchronizer
//   Multi-flop synchroniser for slowly changing level signals (req / ack of
//   the 4-phase handshake). Every stage is cleared by the asynchronous
//   active-low reset, so the output reads 0 until the input level has
//   propagated through all STAGES flops.
//
// Parameters
//   WIDTH   number of independent level bits
//   STAGES  flops in the chain (>= 2)
//
// Ports
//   clk    in  1      destination-domain clock
//   rst_n  in  1      asynchronous reset, active low
//   d      in  WIDTH  asynchronous level input
//   q      out WIDTH  synchronised level (last stage of the chain)
// ---------------------------------------------------------------------------
module level_synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_r [STAGES];

  // Shift the input level through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign q = sync_r[STAGES-1];

endmodule : level_synchronizer

// File: rtl/sync_ack_responder.sv
// ---------------------------------------------------------------------------
// sync_ack_responder
//   Clock-B endpoint of the 4-phase req/ack level handshake. The incoming req
//   level is synchronised, the A-side data word is captured once req is seen
//   and handed to the local consumer as a vld/rdy beat. The ack level goes
//   back to domain A only after the consumer has accepted the beat, and is
//   withdrawn once req has been seen low again.
//
// Build option
//   HS_RX_TIMEOUT_EN  when defined, a watchdog flags (sticky b_err_out) an
//                     ack phase where req stays high for TIMEOUT_CYC cycles.
//                     When undefined b_err_out is tied low.
//
// Ports
//   clk_b         in   1       clock, domain B
//   b_reset_n_in  in   1       asynchronous reset, active low
//   a_req_in      in   1       req level from domain A (asynchronous)
//   a_data_in     in   DATA_W  A-side data, stable while a_req_in is high
//   b_ack_out     out  1       ack level to domain A (registered)
//   b_vld_out     out  1       beat valid to consumer (registered)
//   b_data_out    out  DATA_W  beat data, held while b_vld_out is high
//   b_rdy_in      in   1       consumer ready
//   b_busy_out    out  1       high in every state except IDLE (registered)
//   b_err_out     out  1       sticky ack-phase timeout flag
// ---------------------------------------------------------------------------
module sync_ack_responder
  import hs_cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = HS_SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = HS_TIMEOUT_DEF
) (
  input  logic              clk_b,
  input  logic              b_reset_n_in,
  input  logic              a_req_in,
  input  logic [DATA_W-1:0] a_data_in,
  output logic              b_ack_out,
  output logic              b_vld_out,
  output logic [DATA_W-1:0] b_data_out,
  input  logic              b_rdy_in,
  output logic              b_busy_out,
  output logic              b_err_out
);

  // SETTLE waits until the synchroniser chain has been refilled after reset,
  // so that a req held high across reset is seen before deciding whether the
  // pending transfer must be acknowledged without delivering a beat.
  localparam int               SET_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES);

  logic              req_s;
  hs_state_e         state_r;
  hs_state_e         state_nxt_s;
  logic [SET_W-1:0]  settle_cnt_r;
  logic              settle_done_s;
  logic              vld_r;
  logic              ack_r;
  logic              busy_r;
  logic [DATA_W-1:0] data_r;
  logic              vld_nxt_s;
  logic              ack_nxt_s;
  logic              load_s;

  level_synchronizer #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk_b),
    .rst_n (b_reset_n_in),
    .d     (a_req_in),
    .q     (req_s)
  );

  assign settle_done_s = (settle_cnt_r == SET_LAST);

  // Count post-reset cycles spent in SETTLE until the req chain is valid.
  always_ff @(posedge clk_b or negedge b_reset_n_in) begin
    if (!b_reset_n_in) begin
      settle_cnt_r <= {SET_W{1'b0}};
    end else if ((state_r == SETTLE) && !settle_done_s) begin
      settle_cnt_r <= settle_cnt_r + SET_W'(1'b1);
    end else begin
      settle_cnt_r <= settle_cnt_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_b or negedge b_reset_n_in) begin
    if (!b_reset_n_in) begin
      state_r <= SETTLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SETTLE: begin
        if (settle_done_s) begin
          // A transfer left over from reset is acknowledged but not delivered.
          state_nxt_s = req_s ? ACK : IDLE;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      IDLE: begin
        if (req_s) begin
          state_nxt_s = VALID;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      VALID: begin
        if (vld_r && b_rdy_in) begin
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = VALID;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACK;
        end
      end
      default: begin
        state_nxt_s = SETTLE;
      end
    endcase
  end

  // FSM output decode: next values of the registered outputs.
  always_comb begin
    vld_nxt_s = 1'b0;
    ack_nxt_s = 1'b0;
    case (state_nxt_s)
      VALID:   vld_nxt_s = 1'b1;
      ACK:     ack_nxt_s = 1'b1;
      default: begin
        vld_nxt_s = 1'b0;
        ack_nxt_s = 1'b0;
      end
    endcase
    // a_data_in is only sampled on the IDLE->VALID edge; req has been stable
    // for at least SYNC_STAGES edges by then, so the word is settled.
    if ((state_r == IDLE) && (state_nxt_s == VALID)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Registered handshake outputs and captured data word.
  always_ff @(posedge clk_b or negedge b_reset_n_in) begin
    if (!b_reset_n_in) begin
      vld_r  <= 1'b0;
      ack_r  <= 1'b0;
      busy_r <= 1'b0;
      data_r <= {DATA_W{1'b0}};
    end else begin
      vld_r  <= vld_nxt_s;
      ack_r  <= ack_nxt_s;
      busy_r <= (state_nxt_s != IDLE);
      if (load_s) begin
        data_r <= a_data_in;
      end else begin
        data_r <= data_r;
      end
    end
  end

`ifdef HS_RX_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] wd_cnt_r;
  logic             err_r;

  // Ack-phase watchdog: restart on ACK entry, saturate at the limit.
  always_ff @(posedge clk_b or negedge b_reset_n_in) begin
    if (!b_reset_n_in) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_nxt_s == ACK) && (state_r != ACK)) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ACK) && (wd_cnt_r != CNT_LIMIT)) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1'b1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Sticky timeout flag; purely informational, the handshake is unaffected.
  always_ff @(posedge clk_b or negedge b_reset_n_in) begin
    if (!b_reset_n_in) begin
      err_r <= 1'b0;
    end else if ((state_r == ACK) && req_s && (wd_cnt_r == CNT_LIMIT)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign b_err_out = err_r;
`else
  // Watchdog not built; the limit parameter is intentionally unused here.
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYC > 0);
  assign b_err_out        = 1'b0;
`endif

  assign b_ack_out  = ack_r;
  assign b_vld_out  = vld_r;
  assign b_data_out = data_r;
  assign b_busy_out = busy_r;

endmodule : sync_ack_responder

// File: tb/tb_sync_ack_responder.sv
// ---------------------------------------------------------------------------
// tb_sync_ack_responder
//   Directed bench for sync_ack_responder (DATA_W=8, SYNC_STAGES=2,
//   TIMEOUT_CYC=16). Inputs change 1 time unit after a rising edge, outputs
//   are sampled at that same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_sync_ack_responder;

`ifdef HS_RX_TIMEOUT_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk_b;
  logic       b_reset_n_in;
  logic       a_req_in;
  logic [7:0] a_data_in;
  logic       b_ack_out;
  logic       b_vld_out;
  logic [7:0] b_data_out;
  logic       b_rdy_in;
  logic       b_busy_out;
  logic       b_err_out;

  int n_cmp;
  int n_mis;

  sync_ack_responder #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_b        (clk_b),
    .b_reset_n_in (b_reset_n_in),
    .a_req_in     (a_req_in),
    .a_data_in    (a_data_in),
    .b_ack_out    (b_ack_out),
    .b_vld_out    (b_vld_out),
    .b_data_out   (b_data_out),
    .b_rdy_in     (b_rdy_in),
    .b_busy_out   (b_busy_out),
    .b_err_out    (b_err_out)
  );

  initial clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic got;
    logic dup;
    logic low;
    logic [7:0] beats;

    n_cmp        = 0;
    n_mis        = 0;
    b_reset_n_in = 1'b0;
    a_req_in     = 1'b0;
    a_data_in    = 8'h00;
    b_rdy_in     = 1'b0;

    // Reset state.
    #3;
    chk1("rst_vld", b_vld_out, 1'b0);
    chk1("rst_ack", b_ack_out, 1'b0);
    chk8("rst_data", b_data_out, 8'h00);
    chk1("rst_busy", b_busy_out, 1'b0);
    chk1("rst_err", b_err_out, 1'b0);
    tick();
    tick();
    b_reset_n_in = 1'b1;
    // SETTLE with req low: IDLE after SYNC_STAGES+1 edges.
    tick();
    chk1("settle_busy", b_busy_out, 1'b1);
    tick();
    tick();
    chk1("idle_busy", b_busy_out, 1'b0);
    tick();

    // Basic transfer, consumer always ready.
    a_req_in  = 1'b1;
    a_data_in = 8'hA5;
    b_rdy_in  = 1'b1;
    tick();
    chk1("basic_vld_e1", b_vld_out, 1'b0);
    tick();
    chk1("basic_vld_e2", b_vld_out, 1'b0);
    tick();
    chk1("basic_vld_e3", b_vld_out, 1'b1);
    chk8("basic_data", b_data_out, 8'hA5);
    chk1("basic_ack_e3", b_ack_out, 1'b0);
    tick();
    chk1("basic_vld_e4", b_vld_out, 1'b0);
    chk1("basic_ack_e4", b_ack_out, 1'b1);
    a_req_in = 1'b0;
    tick();
    chk1("basic_ackdn_e1", b_ack_out, 1'b1);
    tick();
    chk1("basic_ackdn_e2", b_ack_out, 1'b1);
    tick();
    chk1("basic_ackdn_e3", b_ack_out, 1'b0);
    chk1("basic_idle", b_busy_out, 1'b0);
    tick();

    // Backpressure for 10 cycles, with data mutation after capture.
    b_rdy_in  = 1'b0;
    a_data_in = 8'hA5;
    a_req_in  = 1'b1;
    tick();
    tick();
    tick();
    chk1("bp_vld_up", b_vld_out, 1'b1);
    a_data_in = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("bp_vld_hold", b_vld_out, 1'b1);
      chk8("bp_data_hold", b_data_out, 8'hA5);
      chk1("bp_ack_low", b_ack_out, 1'b0);
    end
    b_rdy_in = 1'b1;
    tick();
    chk1("bp_vld_done", b_vld_out, 1'b0);
    chk1("bp_ack_up", b_ack_out, 1'b1);
    chk8("bp_data_kept", b_data_out, 8'hA5);
    a_req_in = 1'b0;
    tick();
    tick();
    tick();
    chk1("bp_ack_down", b_ack_out, 1'b0);

    // Back-to-back: four 4-phase transfers.
    beats = 8'd0;
    for (int i = 1; i <= 4; i++) begin
      a_data_in = 8'(i);
      a_req_in  = 1'b1;
      got       = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        tick();
        if (b_vld_out) begin
          got   = 1'b1;
          beats = beats + 8'd1;
          chk8("b2b_data", b_data_out, 8'(i));
        end
      end
      chk1("b2b_vld_seen", got, 1'b1);
      tick();
      chk1("b2b_ack_up", b_ack_out, 1'b1);
      a_req_in = 1'b0;
      dup      = 1'b0;
      low      = 1'b0;
      for (int k = 0; k < 10 && !low; k++) begin
        tick();
        if (b_vld_out) dup = 1'b1;
        if (!b_ack_out) low = 1'b1;
      end
      chk1("b2b_ack_down", low, 1'b1);
      chk1("b2b_no_dup", dup, 1'b0);
    end
    chk8("b2b_beats", beats, 8'd4);
    tick();

    // Reset while in VALID with req held high.
    b_rdy_in  = 1'b0;
    a_data_in = 8'h77;
    a_req_in  = 1'b1;
    tick();
    tick();
    tick();
    chk1("mid_vld_up", b_vld_out, 1'b1);
    b_reset_n_in = 1'b0;
    #1;
    chk1("mid_rst_vld", b_vld_out, 1'b0);
    chk8("mid_rst_data", b_data_out, 8'h00);
    chk1("mid_rst_ack", b_ack_out, 1'b0);
    tick();
    b_reset_n_in = 1'b1;
    b_rdy_in     = 1'b1;
    tick();
    chk1("mid_e1_vld", b_vld_out, 1'b0);
    tick();
    chk1("mid_e2_vld", b_vld_out, 1'b0);
    tick();
    chk1("mid_e3_vld", b_vld_out, 1'b0);
    chk1("mid_e3_ack", b_ack_out, 1'b1);
    a_req_in = 1'b0;
    tick();
    tick();
    tick();
    chk1("mid_ack_down", b_ack_out, 1'b0);
    chk1("mid_idle", b_busy_out, 1'b0);
    chk1("mid_no_beat", b_vld_out, 1'b0);
    tick();

    // Ack-phase watchdog: hold req high after ack.
    a_data_in = 8'h55;
    a_req_in  = 1'b1;
    tick();
    tick();
    tick();
    chk1("wd_vld", b_vld_out, 1'b1);
    tick();
    chk1("wd_ack", b_ack_out, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk1("wd_err_early", b_err_out, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk1("wd_err_late", b_err_out, EXP_ERR);
    chk1("wd_still_ack", b_ack_out, 1'b1);
    a_req_in = 1'b0;
    tick();
    tick();
    tick();
    chk1("wd_ack_down", b_ack_out, 1'b0);
    chk1("wd_err_sticky", b_err_out, EXP_ERR);
    b_reset_n_in = 1'b0;
    #1;
    chk1("wd_err_rst", b_err_out, 1'b0);
    tick();
    b_reset_n_in = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_sync_ack_responder
